// File: rtl/fft_frame_sched.sv
// Purpose: round-robin scheduler sharing one 4-lane FFT core between two frame requesters.
// Latency: request sampled in IDLE -> core start next cycle, beats streamed the cycles after; result window follows core done by one cycle.
// Backpressure: requesters hold REQ until their first GNT; GNT marks each consumed beat, and no new frame is accepted until the current one ends.
module fft_frame_sched #(
  parameter int LOAD_BEATS = 4,
  parameter int TIMEOUT    = 255,
  parameter int FCNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req,
  input  logic [255:0]      i_din0,
  input  logic [255:0]      i_din1,
  output logic [1:0]        o_gnt,
  output logic              o_core_start,
  output logic [63:0]       o_core_d0,
  output logic [63:0]       o_core_d1,
  output logic [63:0]       o_core_d2,
  output logic [63:0]       o_core_d3,
  input  logic              i_core_done,
  output logic              o_res_valid,
  output logic              o_res_id,
  output logic              o_busy,
  output logic              o_err,
  output logic [FCNT_W-1:0] o_frm_cnt
);

  // Beat counter covers 0..LOAD_BEATS-1 (at least one bit); wait counter covers 0..TIMEOUT.
  localparam int BCW = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1;
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(LOAD_BEATS - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_LOAD   = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BCW-1:0]      r_beat;
  logic [WCW-1:0]      r_wait;
  logic                r_owner;
  logic                r_last;
  logic                r_err;
  logic [FCNT_W-1:0]   r_frm_cnt;

  logic                w_pick;
  logic                w_load;
  logic                w_beat_last;
  logic                w_timeout;
  logic                w_frame_done;
  logic [255:0]        w_din_sel;

  assign w_beat_last = (r_beat == BEAT_LAST);

  // Arbitration: a lone requester wins outright; under contention the one that did not own the last frame wins.
  always_comb begin
    w_pick = r_owner;
    case (i_req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = ~r_last;
      default: w_pick = r_owner;
    endcase
  end

  // State register; reset drops any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes; a done on the timeout cycle takes priority over the watchdog.
  always_comb begin
    w_state_nxt  = r_state;
    o_core_start = 1'b0;
    o_gnt        = 2'b00;
    o_res_valid  = 1'b0;
    w_load       = 1'b0;
    w_timeout    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req != 2'b00) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        o_core_start = 1'b1;
        w_state_nxt  = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        o_gnt  = r_owner ? 2'b10 : 2'b01;
        if (w_beat_last) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_core_done) begin
          w_state_nxt = S_UNLOAD;
        end else if (r_wait == WAIT_MAX) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_UNLOAD: begin
        o_res_valid = 1'b1;
        if (w_beat_last) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Owner is latched when a frame is accepted; LAST records who finished (or timed out) most recently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) && (i_req != 2'b00)) begin
        r_owner <= w_pick;
      end
      if (w_timeout || w_frame_done) begin
        r_last <= r_owner;
      end
    end
  end

  // Beat counter is shared by LOAD and UNLOAD; it is back at zero whenever either phase begins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat <= '0;
    end else if ((w_load || o_res_valid) && !w_beat_last) begin
      r_beat <= r_beat + BCW'(1);
    end else begin
      r_beat <= '0;
    end
  end

  // Wait counter runs only while staying in WAIT, so it reads zero on every WAIT entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait <= '0;
    end else if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
      r_wait <= r_wait + WCW'(1);
    end else begin
      r_wait <= '0;
    end
  end

  // Error pulse lands on the first IDLE cycle after a watchdog expiry; completed frames bump the counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err     <= 1'b0;
      r_frm_cnt <= '0;
    end else begin
      r_err <= w_timeout;
      if (w_frame_done) begin
        r_frm_cnt <= r_frm_cnt + FCNT_W'(1);
      end
    end
  end

  // Core lanes follow the owner's beat combinationally during LOAD and are held at zero otherwise.
  assign w_din_sel = r_owner ? i_din1 : i_din0;
  assign o_core_d0 = w_load ? w_din_sel[63:0]    : 64'd0;
  assign o_core_d1 = w_load ? w_din_sel[127:64]  : 64'd0;
  assign o_core_d2 = w_load ? w_din_sel[191:128] : 64'd0;
  assign o_core_d3 = w_load ? w_din_sel[255:192] : 64'd0;

  assign o_busy    = (r_state != S_IDLE);
  assign o_res_id  = r_owner;
  assign o_err     = r_err;
  assign o_frm_cnt = r_frm_cnt;

endmodule

// File: tb/tb_fft_frame_sched.sv
module tb_fft_frame_sched;

  localparam int LB   = 4;
  localparam int TO   = 12;
  localparam int FW   = 2;
  localparam int CW   = 7 + FW;
  localparam int NMAX = 500;
  localparam int PAD  = 64;
  localparam int NTOT = NMAX + PAD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [255:0]  din0;
  logic [255:0]  din1;
  logic          done;
  logic [1:0]    gnt;
  logic          core_start;
  logic [63:0]   cd0, cd1, cd2, cd3;
  logic          res_valid;
  logic          res_id;
  logic          busy;
  logic          err;
  logic [FW-1:0] frm_cnt;

  fft_frame_sched #(.LOAD_BEATS(LB), .TIMEOUT(TO), .FCNT_W(FW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_din0(din0), .i_din1(din1),
    .o_gnt(gnt), .o_core_start(core_start),
    .o_core_d0(cd0), .o_core_d1(cd1), .o_core_d2(cd2), .o_core_d3(cd3),
    .i_core_done(done), .o_res_valid(res_valid), .o_res_id(res_id),
    .o_busy(busy), .o_err(err), .o_frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus and expected-output timelines, one entry per cycle after reset release
  logic [1:0]    s_req  [NTOT];
  logic          s_done [NTOT];
  logic [255:0]  s_din0 [NTOT];
  logic [255:0]  s_din1 [NTOT];
  logic [CW-1:0] e_ctrl [NTOT];
  logic [255:0]  e_data [NTOT];

  // observations gathered while a scenario runs
  int            first_err;
  int            rv_cnt;
  int            owners[$];
  int            cnts[$];

  task automatic check(input string name, input int cyc, input logic [255:0] act, input logic [255:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc %0d got %h exp %h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [CW-1:0] pk(input logic [1:0] g, input logic st, input logic rv,
                                      input logic id, input logic bz, input logic er, input int cnt);
    logic [FW-1:0] c;
    c = cnt[FW-1:0];
    return {g, st, rv, id, bz, er, c};
  endfunction

  function automatic logic [CW-1:0] dut_ctrl();
    return {gnt, core_start, res_valid, res_id, busy, err, frm_cnt};
  endfunction

  function automatic logic [255:0] dut_data();
    return {cd3, cd2, cd1, cd0};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void clear_stim();
    for (int i = 0; i < NTOT; i++) begin
      s_req[i]  = 2'b00;
      s_done[i] = 1'b0;
      s_din0[i] = rnd256();
      s_din1[i] = rnd256();
    end
  endfunction

  // Frame-level reference: walk the timeline frame by frame using the documented timing rules.
  function automatic void build_model(input int n);
    int c, s, w, cnt;
    bit own, last, err_pend;
    for (int i = 0; i < NTOT; i++) begin
      e_ctrl[i] = '0;
      e_data[i] = '0;
    end
    c = 0; cnt = 0; own = 1'b0; last = 1'b1; err_pend = 1'b0;
    while (c < n) begin
      e_ctrl[c] = pk(2'b00, 1'b0, 1'b0, own, 1'b0, err_pend, cnt);
      err_pend = 1'b0;
      if (s_req[c] == 2'b00) begin
        c++;
        continue;
      end
      if (s_req[c] == 2'b01)      own = 1'b0;
      else if (s_req[c] == 2'b10) own = 1'b1;
      else                        own = !last;
      c++;
      e_ctrl[c] = pk(2'b00, 1'b1, 1'b0, own, 1'b1, 1'b0, cnt);
      for (int b = 0; b < LB; b++) begin
        c++;
        e_ctrl[c] = pk(own ? 2'b10 : 2'b01, 1'b0, 1'b0, own, 1'b1, 1'b0, cnt);
        e_data[c] = own ? s_din1[c] : s_din0[c];
      end
      s = c + 1;
      w = -1;
      for (int k = 0; k <= TO; k++) begin
        e_ctrl[s+k] = pk(2'b00, 1'b0, 1'b0, own, 1'b1, 1'b0, cnt);
        if (s_done[s+k]) begin
          w = s + k;
          break;
        end
      end
      last = own;
      if (w < 0) begin
        err_pend = 1'b1;
        c = s + TO + 1;
      end else begin
        for (int b = 1; b <= LB; b++) e_ctrl[w+b] = pk(2'b00, 1'b0, 1'b1, own, 1'b1, 1'b0, cnt);
        cnt = (cnt + 1) % (1 << FW);
        c = w + LB + 1;
      end
    end
  endfunction

  // Reset, check the reset state, and release just after a rising edge; cycle 0 follows.
  task automatic apply_reset(input string name);
    rst_n = 1'b0; req = 2'b00; done = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, "_rst_ctrl"}, -1, 256'(dut_ctrl()), 256'(0));
    check({name, "_rst_data"}, -1, dut_data(), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_scen(input string name, input int n);
    logic [FW-1:0] prev_cnt;
    build_model(n);
    first_err = -1; rv_cnt = 0; owners.delete(); cnts.delete(); prev_cnt = '0;
    apply_reset(name);
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      req = s_req[c]; done = s_done[c]; din0 = s_din0[c]; din1 = s_din1[c];
      @(negedge clk);
      check({name, "_ctrl"}, c, 256'(dut_ctrl()), 256'(e_ctrl[c]));
      check({name, "_data"}, c, dut_data(), e_data[c]);
      if (core_start) owners.push_back(int'(res_id));
      if (res_valid) rv_cnt++;
      if (err && first_err < 0) first_err = c;
      if (frm_cnt != prev_cnt) begin
        cnts.push_back(int'(frm_cnt));
        prev_cnt = frm_cnt;
      end
    end
  endtask

  typedef struct {
    logic [1:0]    req;
    logic          done;
    logic [7:0]    beat;
    logic [CW-1:0] ectrl;
    logic [7:0]    ebeat;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // ---- single-frame table: REQ=01, beats 0x11..0x44, done 10 cycles into WAIT ----
    tbl[0] = '{2'b01, 1'b0, 8'hEE, pk(2'b00, 0, 0, 0, 0, 0, 0), 8'h00};
    tbl[1] = '{2'b01, 1'b0, 8'hEE, pk(2'b00, 1, 0, 0, 1, 0, 0), 8'h00};
    for (int i = 2; i <= 5; i++)
      tbl[i] = '{(i == 2) ? 2'b01 : 2'b00, 1'b0, 8'(8'h11 * (i - 1)),
                 pk(2'b01, 0, 0, 0, 1, 0, 0), 8'(8'h11 * (i - 1))};
    for (int i = 6; i <= 16; i++)
      tbl[i] = '{2'b00, (i == 16), 8'hEE, pk(2'b00, 0, 0, 0, 1, 0, 0), 8'h00};
    for (int i = 17; i <= 20; i++)
      tbl[i] = '{2'b00, 1'b0, 8'hEE, pk(2'b00, 0, 1, 0, 1, 0, 0), 8'h00};
    tbl[21] = '{2'b00, 1'b0, 8'hEE, pk(2'b00, 0, 0, 0, 0, 0, 1), 8'h00};
    tbl[22] = '{2'b00, 1'b0, 8'hEE, pk(2'b00, 0, 0, 0, 0, 0, 1), 8'h00};

    apply_reset("tbl");
    for (int i = 0; i < 23; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      req = tbl[i].req; done = tbl[i].done;
      din0 = {32{tbl[i].beat}}; din1 = {32{8'hA5}};
      @(negedge clk);
      check("tbl_ctrl", i, 256'(dut_ctrl()), 256'(tbl[i].ectrl));
      check("tbl_data", i, dut_data(), {32{tbl[i].ebeat}});
    end

    // ---- contention: both request continuously, done held high ----
    clear_stim();
    for (int i = 0; i < 120; i++) begin
      s_req[i] = 2'b11;
      s_done[i] = 1'b1;
    end
    run_scen("cont", 120);
    check("cont_nown", 0, 256'(owners.size() >= 4), 256'(1));
    for (int k = 0; k < 4; k++)
      if (k < owners.size()) check("cont_owner", k, 256'(owners[k]), 256'(k % 2));

    // ---- timeout, then contention goes to the other requester ----
    clear_stim();
    for (int i = 0; i <= 2; i++) s_req[i] = 2'b01;
    for (int i = 25; i < 60; i++) s_req[i] = 2'b11;
    run_scen("tmo", 60);
    check("tmo_err_cyc", 0, 256'(first_err), 256'(19));
    check("tmo_cnt_still", 0, 256'(cnts.size()), 256'(0));
    if (owners.size() >= 2) check("tmo_next_owner", 1, 256'(owners[1]), 256'(1));
    else check("tmo_nstarts", 0, 256'(owners.size()), 256'(2));

    // ---- done arrives exactly on the timeout cycle ----
    clear_stim();
    for (int i = 0; i <= 2; i++) s_req[i] = 2'b01;
    s_done[18] = 1'b1;
    run_scen("dto", 40);
    check("dto_no_err", 0, 256'(first_err), 256'(-1));
    check("dto_rv", 0, 256'(rv_cnt), 256'(4));

    // ---- done pulses in IDLE and LOAD are ignored ----
    clear_stim();
    for (int i = 3; i <= 5; i++) s_req[i] = 2'b01;
    s_done[1] = 1'b1;
    s_done[6] = 1'b1;
    run_scen("ign", 40);
    check("ign_rv", 0, 256'(rv_cnt), 256'(0));
    check("ign_err_cyc", 0, 256'(first_err), 256'(22));

    // ---- frame counter wrap with a 2-bit counter ----
    clear_stim();
    for (int i = 0; i < 60; i++) begin
      s_req[i] = 2'b01;
      s_done[i] = 1'b1;
    end
    run_scen("wrap", 60);
    check("wrap_n", 0, 256'(cnts.size() >= 5), 256'(1));
    for (int k = 0; k < 5; k++)
      if (k < cnts.size()) check("wrap_cnt", k, 256'(cnts[k]), 256'((k + 1) % 4));

    // ---- randomized traffic against the frame-level model ----
    for (int r = 0; r < 3; r++) begin
      clear_stim();
      for (int i = 0; i < NMAX; i++) begin
        s_req[i]  = 2'($urandom_range(0, 3));
        s_done[i] = ($urandom_range(0, 9) == 0);
      end
      run_scen("rand", NMAX);
    end

    // ---- reset during LOAD beat 2 of a second frame ----
    apply_reset("mid");
    req = 2'b01; done = 1'b1; din0 = rnd256(); din1 = rnd256();
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("mid_pre_gnt", 15, 256'(gnt), 256'(2'b01));
    check("mid_pre_cnt", 15, 256'(frm_cnt), 256'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_async_ctrl", 15, 256'(dut_ctrl()), 256'(0));
    check("mid_async_data", 15, dut_data(), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1; req = 2'b11; done = 1'b0;
    @(negedge clk);
    check("mid_c0", 0, 256'(dut_ctrl()), 256'(pk(2'b00, 0, 0, 0, 0, 0, 0)));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_c1", 1, 256'(dut_ctrl()), 256'(pk(2'b00, 1, 0, 0, 1, 0, 0)));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_c2", 2, 256'(dut_ctrl()), 256'(pk(2'b01, 0, 0, 0, 1, 0, 0)));
    check("mid_c2_data", 2, dut_data(), din0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
